// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller, its datapath and its bench.
// Holds the opcode/funct constants, the ALU operation encodings, the FSM state
// enumeration and the record of registered decode controls.
package multicycle_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_SLTIU  = 6'b001011;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] FUNCT_SRA = 6'b000011;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_BEQ   = 3'b001,
    ALU_RTYPE = 3'b010,
    ALU_LUI   = 3'b011,
    ALU_OR    = 3'b100,
    ALU_BNE   = 3'b101,
    ALU_SLTU  = 3'b110
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXEC_R  = 3'd2,
    ST_EXEC_I  = 3'd3,
    ST_EXEC_BR = 3'd4,
    ST_WB      = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    CLS_ILLEGAL = 2'd0,
    CLS_R       = 2'd1,
    CLS_I       = 2'd2,
    CLS_BR      = 2'd3
  } instr_class_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src;
    logic    reg_dst;
    logic    shift;
    logic    se;
  } ctrl_dec_t;

endpackage

// File: rtl/ctrl_decode_table.sv
// Combinational instruction decode table.
// Ports:
//   op_i    - opcode field
//   funct_i - funct field (only meaningful for R-type)
//   dec_o   - datapath controls for the instruction (all zero when unsupported)
//   cls_o   - instruction class, CLS_ILLEGAL for unsupported opcodes
module ctrl_decode_table
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0]   op_i,
  input  logic [5:0]   funct_i,
  output ctrl_dec_t    dec_o,
  output instr_class_e cls_o
);

  always_comb begin
    dec_o = '0;
    cls_o = CLS_ILLEGAL;
    case (op_i)
      OP_RTYPE: begin
        dec_o.alu_op  = ALU_RTYPE;
        dec_o.reg_dst = 1'b1;
        dec_o.shift   = (funct_i == FUNCT_SRA);
        cls_o         = CLS_R;
      end
      OP_BEQ: begin
        dec_o.alu_op = ALU_BEQ;
        dec_o.se     = 1'b1;
        cls_o        = CLS_BR;
      end
      OP_BNE: begin
        dec_o.alu_op = ALU_BNE;
        dec_o.se     = 1'b1;
        cls_o        = CLS_BR;
      end
      OP_ADDI: begin
        dec_o.alu_op  = ALU_ADD;
        dec_o.alu_src = 1'b1;
        dec_o.se      = 1'b1;
        cls_o         = CLS_I;
      end
      OP_SLTIU: begin
        dec_o.alu_op  = ALU_SLTU;
        dec_o.alu_src = 1'b1;
        cls_o         = CLS_I;
      end
      OP_ORI: begin
        dec_o.alu_op  = ALU_OR;
        dec_o.alu_src = 1'b1;
        cls_o         = CLS_I;
      end
      OP_LUI: begin
        dec_o.alu_op  = ALU_LUI;
        dec_o.alu_src = 1'b1;
        dec_o.se      = 1'b1;
        cls_o         = CLS_I;
      end
      default: begin
        dec_o = '0;
        cls_o = CLS_ILLEGAL;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control unit: FETCH / DECODE / EXEC / WB sequencer,
// registered decode controls and a retired-instruction counter.
// Ports:
//   clk_i, rst_i          - clock, synchronous active-high reset
//   imem_ready_i          - instruction word valid (FETCH advances on it)
//   hold_i                - freeze: state, decode regs and counter hold, strobes low
//   instr_op_i, funct_i   - opcode/funct of the current instruction word
//   zero_i                - ALU zero flag, used for branch resolution
//   IRWrite_o, PCWrite_o  - FETCH strobes
//   PCSrc_o               - branch taken strobe in EXEC_BR
//   RegWrite_o            - register write strobe in WB
//   ALU_op_o .. SE_o      - registered decode controls, loaded in DECODE
//   instr_done_o          - retire pulse; illegal_o - unsupported opcode pulse
//   state_o               - current state; instr_cnt_o - retired count (wraps)
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        imem_ready_i,
  input  logic        hold_i,
  input  logic [5:0]  instr_op_i,
  input  logic [5:0]  funct_i,
  input  logic        zero_i,
  output logic        IRWrite_o,
  output logic        PCWrite_o,
  output logic        PCSrc_o,
  output logic        RegWrite_o,
  output logic [2:0]  ALU_op_o,
  output logic        ALUSrc_o,
  output logic        RegDst_o,
  output logic        shift_o,
  output logic        SE_o,
  output logic        instr_done_o,
  output logic        illegal_o,
  output logic [2:0]  state_o,
  output logic [31:0] instr_cnt_o
);

  state_e       state_q, state_d;
  ctrl_dec_t    dec_q, dec_d;
  logic [31:0]  instr_cnt_q, instr_cnt_d;
  ctrl_dec_t    tbl_dec;
  instr_class_e tbl_cls;
  logic         go;

  ctrl_decode_table u_decode (
    .op_i    (instr_op_i),
    .funct_i (funct_i),
    .dec_o   (tbl_dec),
    .cls_o   (tbl_cls)
  );

  // Strobes are issued from the current state while not held; since held
  // states keep their _q values, the same strobes reissue once hold_i drops.
  // No strobe is issued in a cycle where reset is being applied.
  assign go = !hold_i && !rst_i;

  always_comb begin
    state_d      = state_q;
    dec_d        = dec_q;
    instr_cnt_d  = instr_cnt_q;
    IRWrite_o    = 1'b0;
    PCWrite_o    = 1'b0;
    PCSrc_o      = 1'b0;
    RegWrite_o   = 1'b0;
    instr_done_o = 1'b0;
    illegal_o    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (go && imem_ready_i) begin
          IRWrite_o = 1'b1;
          PCWrite_o = 1'b1;
          state_d   = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (go) begin
          dec_d = tbl_dec;
          case (tbl_cls)
            CLS_R:   state_d = ST_EXEC_R;
            CLS_I:   state_d = ST_EXEC_I;
            CLS_BR:  state_d = ST_EXEC_BR;
            default: begin
              illegal_o = 1'b1;
              state_d   = ST_FETCH;
            end
          endcase
        end
      end
      ST_EXEC_R, ST_EXEC_I: begin
        if (go) state_d = ST_WB;
      end
      ST_EXEC_BR: begin
        if (go) begin
          // beq/bne distinguished by the registered ALU op, not the live opcode
          PCSrc_o      = (dec_q.alu_op == ALU_BNE) ? ~zero_i : zero_i;
          instr_done_o = 1'b1;
          state_d      = ST_FETCH;
        end
      end
      ST_WB: begin
        if (go) begin
          RegWrite_o   = 1'b1;
          instr_done_o = 1'b1;
          state_d      = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
    if (instr_done_o) instr_cnt_d = instr_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_FETCH;
      dec_q       <= '0;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      dec_q       <= dec_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign ALU_op_o    = dec_q.alu_op;
  assign ALUSrc_o    = dec_q.alu_src;
  assign RegDst_o    = dec_q.reg_dst;
  assign shift_o     = dec_q.shift;
  assign SE_o        = dec_q.se;
  assign state_o     = state_q;
  assign instr_cnt_o = instr_cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against an
// instruction-level reference model.
module tb_multicycle_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0, imem_ready_i = 1'b0, hold_i = 1'b0, zero_i = 1'b0;
  logic [5:0]  instr_op_i = '0, funct_i = '0;
  logic        IRWrite_o, PCWrite_o, PCSrc_o, RegWrite_o, ALUSrc_o, RegDst_o;
  logic        shift_o, SE_o, instr_done_o, illegal_o;
  logic [2:0]  ALU_op_o, state_o;
  logic [31:0] instr_cnt_o;

  int checks = 0;
  int errors = 0;
  int ncyc   = 0;

  // Reference model: progress through an instruction as a step number
  // (0 fetch, 1 decode, 2 execute, 3 writeback) plus instruction kind.
  bit          m_valid = 1'b0;
  int          m_step  = 0;
  int          m_kind  = 0;        // 0 R-type, 1 I-type, 2 branch
  bit          m_bne   = 1'b0;
  logic [6:0]  m_dec   = '0;       // {alu_op, alusrc, regdst, shift, se}
  logic [31:0] m_cnt   = '0;

  always #5 clk_i = ~clk_i;

  multicycle_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .imem_ready_i(imem_ready_i), .hold_i(hold_i),
    .instr_op_i(instr_op_i), .funct_i(funct_i), .zero_i(zero_i),
    .IRWrite_o(IRWrite_o), .PCWrite_o(PCWrite_o), .PCSrc_o(PCSrc_o),
    .RegWrite_o(RegWrite_o), .ALU_op_o(ALU_op_o), .ALUSrc_o(ALUSrc_o),
    .RegDst_o(RegDst_o), .shift_o(shift_o), .SE_o(SE_o),
    .instr_done_o(instr_done_o), .illegal_o(illegal_o), .state_o(state_o),
    .instr_cnt_o(instr_cnt_o)
  );

  // {legal, alu_op[2:0], alusrc, regdst, shift, se}
  function automatic logic [7:0] ref_decode(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'd0:    return {1'b1, 3'b010, 1'b0, 1'b1, (fn == 6'd3), 1'b0};
      6'd4:    return {1'b1, 3'b001, 4'b0001};
      6'd5:    return {1'b1, 3'b101, 4'b0001};
      6'd8:    return {1'b1, 3'b000, 4'b1001};
      6'd11:   return {1'b1, 3'b110, 4'b1000};
      6'd13:   return {1'b1, 3'b100, 4'b1000};
      6'd15:   return {1'b1, 3'b011, 4'b1001};
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [15:0] dut_vec();
    return {state_o, ALU_op_o, ALUSrc_o, RegDst_o, shift_o, SE_o,
            IRWrite_o, PCWrite_o, PCSrc_o, RegWrite_o, instr_done_o, illegal_o};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, ncyc, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare DUT against the model, advance model.
  task automatic cyc(input logic r, input logic rdy, input logic h,
                     input logic [5:0] op, input logic [5:0] fn, input logic z);
    logic [7:0]  d;
    logic [2:0]  st;
    logic        irw, pcw, pcs, rw, dn, ill;
    @(negedge clk_i);
    ncyc++;
    rst_i = r; imem_ready_i = rdy; hold_i = h;
    instr_op_i = op; funct_i = fn; zero_i = z;
    #1;
    d = ref_decode(op, fn);
    {irw, pcw, pcs, rw, dn, ill} = '0;
    case (m_step)
      0:       st = 3'd0;
      1:       st = 3'd1;
      2:       st = (m_kind == 2) ? 3'd4 : ((m_kind == 0) ? 3'd2 : 3'd3);
      default: st = 3'd5;
    endcase
    if (!r && !h) begin
      case (m_step)
        0: begin irw = rdy; pcw = rdy; end
        1: ill = ~d[7];
        2: if (m_kind == 2) begin pcs = m_bne ? ~z : z; dn = 1'b1; end
        default: begin rw = 1'b1; dn = 1'b1; end
      endcase
    end
    if (m_valid) begin
      chk("outputs", {16'h0, dut_vec()}, {16'h0, st, m_dec, irw, pcw, pcs, rw, dn, ill});
      chk("instr_cnt", instr_cnt_o, m_cnt);
    end
    if (r) begin
      m_valid = 1'b1; m_step = 0; m_dec = '0; m_cnt = '0;
    end else if (!h) begin
      case (m_step)
        0: if (rdy) m_step = 1;
        1: begin
          m_dec = d[6:0];
          if (!d[7]) m_step = 0;
          else begin
            m_step = 2;
            m_kind = (op == 6'd0) ? 0 : ((op == 6'd4 || op == 6'd5) ? 2 : 1);
            m_bne  = (op == 6'd5);
          end
        end
        2: if (m_kind == 2) begin m_step = 0; m_cnt = m_cnt + 32'd1; end
           else m_step = 3;
        default: begin m_step = 0; m_cnt = m_cnt + 32'd1; end
      endcase
    end
  endtask

  initial begin
    logic [5:0] ops [9];
    logic [5:0] r_op, r_fn;
    ops = '{6'd0, 6'd4, 6'd5, 6'd8, 6'd11, 6'd13, 6'd15, 6'h23, 6'h02};
    r_op = '0; r_fn = '0;

    // Reset, including with hold and ready asserted
    cyc(1, 0, 0, 6'd0, 6'd0, 0);
    cyc(1, 1, 1, 6'd0, 6'd0, 0);
    cyc(0, 0, 0, 6'd0, 6'd0, 0);
    chk("reset_outs", {16'h0, dut_vec()}, 32'h0);
    chk("reset_cnt", instr_cnt_o, 32'h0);

    // add
    cyc(0, 1, 0, 6'd0, 6'h20, 0);
    chk("add_fetch_state", state_o, 0); chk("add_irwrite", IRWrite_o, 1); chk("add_pcwrite", PCWrite_o, 1);
    cyc(0, 1, 0, 6'd0, 6'h20, 0);
    chk("add_decode_state", state_o, 1); chk("add_rw_c2", RegWrite_o, 0);
    cyc(0, 1, 0, 6'd0, 6'h20, 0);
    chk("add_exec_state", state_o, 2); chk("add_aluop", ALU_op_o, 3'b010);
    chk("add_regdst", RegDst_o, 1); chk("add_rw_c3", RegWrite_o, 0);
    cyc(0, 1, 0, 6'd0, 6'h20, 0);
    chk("add_wb_state", state_o, 5); chk("add_rw_c4", RegWrite_o, 1); chk("add_cnt_wb", instr_cnt_o, 0);
    cyc(0, 0, 0, 6'd0, 6'h20, 0);
    chk("add_cnt_after", instr_cnt_o, 1); chk("add_rw_after", RegWrite_o, 0);

    // beq then bne, both with zero set
    cyc(0, 1, 0, 6'd4, 6'd0, 1); cyc(0, 1, 0, 6'd4, 6'd0, 1); cyc(0, 1, 0, 6'd4, 6'd0, 1);
    chk("beq_state", state_o, 4); chk("beq_pcsrc", PCSrc_o, 1);
    chk("beq_aluop", ALU_op_o, 3'b001); chk("beq_done", instr_done_o, 1);
    cyc(0, 1, 0, 6'd5, 6'd0, 1); cyc(0, 1, 0, 6'd5, 6'd0, 1); cyc(0, 1, 0, 6'd5, 6'd0, 1);
    chk("bne_state", state_o, 4); chk("bne_pcsrc", PCSrc_o, 0);
    chk("bne_aluop", ALU_op_o, 3'b101); chk("bne_done", instr_done_o, 1);

    // sra, ori, lui
    cyc(0, 1, 0, 6'd0, 6'd3, 0); cyc(0, 1, 0, 6'd0, 6'd3, 0); cyc(0, 1, 0, 6'd0, 6'd3, 0);
    chk("sra_shift", shift_o, 1); chk("sra_se", SE_o, 0);
    cyc(0, 1, 0, 6'd0, 6'd3, 0);
    cyc(0, 1, 0, 6'd13, 6'd0, 0); cyc(0, 1, 0, 6'd13, 6'd0, 0); cyc(0, 1, 0, 6'd13, 6'd0, 0);
    chk("ori_se", SE_o, 0); chk("ori_alusrc", ALUSrc_o, 1);
    cyc(0, 1, 0, 6'd13, 6'd0, 0);
    cyc(0, 1, 0, 6'd15, 6'd0, 0); cyc(0, 1, 0, 6'd15, 6'd0, 0); cyc(0, 1, 0, 6'd15, 6'd0, 0);
    chk("lui_aluop", ALU_op_o, 3'b011); chk("lui_se", SE_o, 1);
    cyc(0, 1, 0, 6'd15, 6'd0, 0);

    // unsupported opcode
    cyc(0, 1, 0, 6'h23, 6'd0, 0); cyc(0, 1, 0, 6'h23, 6'd0, 0);
    chk("ill_state", state_o, 1); chk("ill_pulse", illegal_o, 1); chk("ill_rw", RegWrite_o, 0);
    cyc(0, 0, 0, 6'h23, 6'd0, 0);
    chk("ill_back_fetch", state_o, 0); chk("ill_pulse_end", illegal_o, 0); chk("ill_cnt", instr_cnt_o, 6);

    // ready low, then hold during writeback
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 6'd0, 6'h20, 0);
      chk("wait_state", state_o, 0); chk("wait_irwrite", IRWrite_o, 0);
    end
    cyc(0, 1, 0, 6'd0, 6'h20, 0); cyc(0, 1, 0, 6'd0, 6'h20, 0); cyc(0, 1, 0, 6'd0, 6'h20, 0);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 1, 1, 6'd0, 6'h20, 0);
      chk("hold_state", state_o, 5); chk("hold_rw", RegWrite_o, 0); chk("hold_done", instr_done_o, 0);
    end
    cyc(0, 1, 0, 6'd0, 6'h20, 0);
    chk("unhold_rw", RegWrite_o, 1);
    cyc(0, 0, 0, 6'd0, 6'h20, 0);
    chk("unhold_cnt", instr_cnt_o, 7); chk("unhold_rw_once", RegWrite_o, 0);

    // reset in EXEC_I, then counter wrap
    cyc(0, 1, 0, 6'd8, 6'd0, 0); cyc(0, 1, 0, 6'd8, 6'd0, 0); cyc(0, 1, 0, 6'd8, 6'd0, 0);
    chk("addi_exec_state", state_o, 3);
    cyc(1, 1, 0, 6'd8, 6'd0, 0);
    cyc(0, 0, 0, 6'd8, 6'd0, 0);
    chk("rst_mid_outs", {16'h0, dut_vec()}, 32'h0); chk("rst_mid_cnt", instr_cnt_o, 0);
    dut.instr_cnt_q = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 6'd0, 6'h20, 0);
    chk("wrap_before", instr_cnt_o, 32'hFFFF_FFFF);
    cyc(0, 0, 0, 6'd0, 6'h20, 0);
    chk("wrap_after", instr_cnt_o, 32'h0);

    // randomized traffic; opcode/funct held stable across an instruction
    for (int i = 0; i < 3000; i++) begin
      if (m_step == 0) begin
        r_op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 8)];
        r_fn = ($urandom_range(0, 3) == 0) ? 6'd3 : 6'($urandom);
      end
      cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 5) == 0), r_op, r_fn, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have ports, one per line, as listed (clock and reset first):
  clk_i  in  1  single clock; all state updates on rising edge
  rst_i  in  1  reset, synchronous, active-high
  imem_ready_i  in  1  instruction memory data valid this cycle
  hold_i  in  1  freeze request from debug/hazard logic
  instr_op_i  in  6  opcode field of current instruction word (from memory in FETCH, from IR afterwards)
  funct_i  in  6  funct field of the same word
  zero_i  in  1  ALU zero flag
  IRWrite_o  out  1  load instruction register
  PCWrite_o  out  1  unconditional PC <- PC+4
  PCSrc_o  out  1  branch taken: PC <- branch target
  RegWrite_o  out  1  register-file write strobe
  ALU_op_o  out  3  ALU operation code
  ALUSrc_o  out  1  1 = immediate operand
  RegDst_o  out  1  1 = rd, 0 = rt
  shift_o  out  1  shift-amount operand select
  SE_o  out  1  1 = sign-extend, 0 = zero-extend immediate
  instr_done_o  out  1  one-cycle pulse on instruction retire
  illegal_o  out  1  one-cycle pulse on unsupported opcode
  state_o  out  3  current FSM state encoding
  instr_cnt_o  out  32  retired-instruction count
REQ-002 SHALL have no parameters; the supported instruction set is fixed.

Function
REQ-003 FSM states SHALL be FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, EXEC_BR=4, WB=5; other encodings go to FETCH next cycle.
REQ-004 FETCH: stays in FETCH while imem_ready_i=0; when 1, IRWrite_o=1 and PCWrite_o=1 for that cycle, then DECODE.
REQ-005 DECODE: registers ALU_op_o, ALUSrc_o, RegDst_o, shift_o, SE_o from the IR fields; next state EXEC_R (op 000000), EXEC_BR (000100, 000101), EXEC_I (001000, 001011, 001101, 001111); any other op: illegal_o=1 for one cycle, no register write, return to FETCH.
REQ-006 Decode table SHALL be: R ALU_op 010 ALUSrc 0 RegDst 1; beq 001; bne 101; addi 000; sltiu 110; lui 011; ori 100; I-type ALUSrc 1 RegDst 0; branches ALUSrc 0.
REQ-007 shift_o SHALL be 1 only for R-type with funct 000011 (sra); SE_o SHALL be 1 for addi, beq, bne, lui, 0 for sltiu, ori and sra, 0 for other R-type.
REQ-008 Registered decode outputs SHALL stay constant from the cycle after DECODE through the last cycle of the instruction.
REQ-009 EXEC_R and EXEC_I last one cycle each and go to WB; WB asserts RegWrite_o=1 and instr_done_o=1 for one cycle, then FETCH.
REQ-010 EXEC_BR lasts one cycle: PCSrc_o = zero_i for beq, ~zero_i for bne; instr_done_o=1; then FETCH.
REQ-011 Latency with imem_ready_i already high SHALL be 4 cycles for R/I-type and 3 cycles for branches, FETCH to retire inclusive.
REQ-012 IRWrite_o, PCWrite_o, PCSrc_o, RegWrite_o, instr_done_o, illegal_o SHALL each be high for at most one cycle per instruction.
REQ-013 hold_i=1 SHALL freeze state, decode registers and counter, and force all strobes low; hold_i has priority over imem_ready_i in the same cycle; the frozen state's strobes reissue once hold_i falls.
REQ-014 instr_cnt_o SHALL increment by 1 on each instr_done_o pulse (not on illegal) and wrap from FFFFFFFF to 0.

Reset
REQ-015 When rst_i=1 at a clock edge: state FETCH, instr_cnt_o 0, every other output 0 (SE_o 0, ALU_op_o 000), regardless of current state or hold_i.
REQ-016 Reset mid-instruction SHALL abort it without asserting RegWrite_o, PCSrc_o or instr_done_o in the cycle after reset.

Structure
REQ-017 A shared package SHALL hold opcode and funct constants, the ALU_op encodings and the state enumeration, for reuse by the datapath and bench.
REQ-018 The decode table SHALL be a combinational sub-module ctrl_decode_table; the FSM, decode registers and counter reside in multicycle_ctrl.

Verification
REQ-019 add (op 000000, funct 100000), ready high -> states 0,1,2,5; RegWrite_o=1 cycle 4 only; ALU_op_o=010, RegDst_o=1; instr_cnt_o 0->1.
REQ-020 beq with zero_i=1, then bne with zero_i=1 -> PCSrc_o 1 then 0 in EXEC_BR; each retires in 3 cycles; ALU_op_o 001 then 101.
REQ-021 sra (funct 000011) -> shift_o=1, SE_o=0; ori -> SE_o=0, ALUSrc_o=1; lui -> ALU_op_o=011, SE_o=1.
REQ-022 op 100011 -> illegal_o one-cycle pulse in DECODE, no RegWrite_o, back to FETCH, instr_cnt_o unchanged.
REQ-023 imem_ready_i low 3 cycles, then hold_i high 2 cycles in WB -> FETCH held 3 cycles; RegWrite_o low during hold, pulses once after.
REQ-024 rst_i asserted in EXEC_I -> next cycle FETCH, all outputs 0; counter preset near FFFFFFFF wraps to 0 on retire.
